reg_bank: RTL and testbench
===========================

Name: reg_bank

Overview:
- Multi-entry register bank sitting directly upstream of the processor's pipeline registers; supplies their N-bit operands.
- Holds DEPTH words of N bits.
- Two combinational read ports, one synchronous write port with same-cycle write-to-read bypass.
- Sequential clear engine zeroes the whole bank, one entry per cycle, on request (context switch / new image job) without a reset.

Parameters:
- N, 24, data width in bits.
- DEPTH, 16, number of entries; must be a power of two, >= 2.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset: 0 resets immediately, release is synchronous to clk.
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  N  write data.
- raddr_a  input  AW  read address, port A.
- rdata_a  output  N  read data, port A; combinational.
- raddr_b  input  AW  read address, port B.
- rdata_b  output  N  read data, port B; combinational.
- clr_req  input  1  one-cycle request to start a bank clear.
- clr_busy  output  1  high while the clear sweep runs.
- clr_done  output  1  one-cycle pulse after the last entry is cleared.

Behaviour:
- Reset (rst=0): all entries 0; FSM to IDLE; sweep counter 0; clr_busy=0; clr_done=0. Takes effect asynchronously, including mid-sweep; the sweep is abandoned.
- Write: at posedge clk, if we=1 and clr_busy=0, entry[waddr] <= wdata.
  - While clr_busy=1, writes are dropped; the producer must gate on clr_busy.
- Read: rdata_x = entry[raddr_x], combinational, zero-cycle latency.
- Bypass: if we=1, clr_busy=0 and waddr==raddr_x, then rdata_x = wdata in the same cycle. Applies to each port independently; both ports may bypass at once.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 -> CLEAR, counter <= 0. A write in that same cycle is still performed, since clr_busy is 0.
  - CLEAR: clr_busy=1; each cycle entry[counter] <= 0 and counter <= counter+1. When counter == DEPTH-1 -> DONE. Sweep lasts exactly DEPTH cycles.
  - DONE: clr_done=1 for one cycle, clr_busy=0 -> IDLE.
- clr_req while in CLEAR or DONE is ignored, not queued.
- During CLEAR, reads return the current stored value: already-swept entries read 0, unswept entries keep old data.
- Counter is AW bits and wraps only via the terminal compare; no overflow state.
- Outputs clr_busy and clr_done are registered state decodes, glitch-free.

Optional Feature:
- Macro: REG_BANK_ZERO_REG_EN.
- Defined: entry 0 is hardwired to zero.
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0, even when a bypass write targets 0.
  - The sweep still runs DEPTH cycles.
- Undefined: entry 0 is an ordinary read/write entry.

Decomposition:
- Package reg_bank_pkg:
  - state enum (IDLE, CLEAR, DONE), 2-bit typedef.
  - default N/DEPTH localparams.
  - data word typedef.
- Sub-module reg_bank_clr_fsm: state register, sweep counter, clr_busy, clr_done, and clear-address/clear-enable outputs to the storage array.
- The storage array, write logic and bypass muxes stay in reg_bank.

Test Plan:
- Reset then read all addresses: every rdata = 0; clr_busy=0, clr_done=0.
- Write 0xABCDEF to addr 5; same cycle raddr_a=5 -> rdata_a=0xABCDEF (bypass). Next cycle with we=0 -> still 0xABCDEF; raddr_b=6 -> 0.
- Fill all 16 entries with 0x100000+i, pulse clr_req:
  - clr_busy high for exactly 16 cycles; clr_done pulses on cycle 17.
  - Mid-sweep at cycle 8, entry 3 reads 0 and entry 12 reads 0x10000C.
  - After done, all entries read 0.
- During CLEAR, drive we=1, waddr=15, wdata=0x123456 -> write dropped; entry 15 reads 0 after done. A second clr_req mid-sweep leaves the sweep length unchanged.
- Assert rst=0 at sweep cycle 4, between clock edges: immediately clr_busy=0 and all entries 0. After release, a write to addr 2 works normally.
- With REG_BANK_ZERO_REG_EN: write 0xFFFFFF to addr 0 -> rdata_a=0 in the same cycle and the next. Writes to addr 1 work normally.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the reg_bank register file.
//   clr_state_e : clear-engine states (idle, sweeping, one-cycle done).
//   DefaultN / DefaultDepth : default data width and entry count.
//   word_t      : one data word at the default width.
package reg_bank_pkg;

  localparam int unsigned DefaultN     = 24;
  localparam int unsigned DefaultDepth = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StDone  = 2'd2
  } clr_state_e;

  typedef logic [DefaultN-1:0] word_t;

endpackage

// File: rtl/reg_bank_clr_fsm.sv
// Clear engine for reg_bank: sweeps every entry to zero, one per cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clr_req    : one-cycle start request (ignored unless idle)
//   clr_busy   : high for exactly DEPTH cycles while sweeping
//   clr_done   : one-cycle pulse in the cycle after the last entry is cleared
//   clr_en     : write-zero strobe to the storage array
//   clr_addr   : entry being cleared this cycle
module reg_bank_clr_fsm
  import reg_bank_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        // Counter wraps naturally at DEPTH-1; the terminal compare ends the sweep.
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Pure decodes of the state register, so both outputs are glitch-free.
  assign clr_busy = (state_q == StClear);
  assign clr_done = (state_q == StDone);
  assign clr_en   = clr_busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_bank.sv
// Register bank: DEPTH x N storage, two combinational read ports, one
// synchronous write port with same-cycle write-to-read bypass, and a
// sequential clear engine that zeroes the bank without a reset.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   we, waddr, wdata  : write port (dropped while clr_busy)
//   raddr_a, rdata_a  : read port A (combinational, bypassed)
//   raddr_b, rdata_b  : read port B (combinational, bypassed)
//   clr_req           : start a bank clear
//   clr_busy, clr_done: clear sweep status
// Build option: define REG_BANK_ZERO_REG_EN to hardwire entry 0 to zero.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [N-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [N-1:0]  rdata_b,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done
);

  logic [N-1:0]  mem_q [DEPTH];
  logic          clr_en;
  logic [AW-1:0] clr_addr;
  logic          wr_en;

  reg_bank_clr_fsm #(
    .DEPTH (DEPTH)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  // Effective write: suppressed during the sweep, and for entry 0 when it is hardwired.
`ifdef REG_BANK_ZERO_REG_EN
  assign wr_en = we && !clr_busy && (waddr != '0);
`else
  assign wr_en = we && !clr_busy;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (clr_en && (clr_addr == AW'(i))) begin
          mem_q[i] <= '0;
        end else if (wr_en && (waddr == AW'(i))) begin
          mem_q[i] <= wdata;
        end
      end
    end
  end

  always_comb begin
    rdata_a = mem_q[raddr_a];
    if (wr_en && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
`ifdef REG_BANK_ZERO_REG_EN
    if (raddr_a == '0) begin
      rdata_a = '0;
    end
`endif
  end

  always_comb begin
    rdata_b = mem_q[raddr_b];
    if (wr_en && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
`ifdef REG_BANK_ZERO_REG_EN
    if (raddr_b == '0) begin
      rdata_b = '0;
    end
`endif
  end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank (default N=24, DEPTH=16).
// Expected values are queued as stimulus is driven and compared at the
// sample point half a cycle away from the rising edge.
module tb_reg_bank;

  localparam int unsigned N     = 24;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [N-1:0]  wdata;
  logic [AW-1:0] raddr_a;
  logic [N-1:0]  rdata_a;
  logic [AW-1:0] raddr_b;
  logic [N-1:0]  rdata_b;
  logic          clr_req;
  logic          clr_busy;
  logic          clr_done;

  reg_bank #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (raddr_a),
    .rdata_a  (rdata_a),
    .raddr_b  (raddr_b),
    .rdata_b  (rdata_b),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {SelA, SelB, SelBusy, SelDone} sel_e;
  typedef struct {
    string        tag;
    sel_e         sel;
    logic [N-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input sel_e sel, input logic [N-1:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Compare every queued expectation against the current DUT outputs.
  task automatic drain();
    exp_t         e;
    logic [N-1:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SelA:    obs = rdata_a;
        SelB:    obs = rdata_b;
        SelBusy: obs = N'(clr_busy);
        default: obs = N'(clr_done);
      endcase
      check_val(e.tag, obs, e.exp);
    end
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [N-1:0] d);
    @(negedge clk);
    we    = 1'b1;
    waddr = a;
    wdata = d;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      raddr_a = AW'(i);
      raddr_b = AW'(DEPTH - 1 - i);
      push_exp($sformatf("%s_a%0d", tag, i), SelA, '0);
      push_exp($sformatf("%s_b%0d", tag, DEPTH - 1 - i), SelB, '0);
      #1 drain();
    end
  endtask

  initial begin
    rst     = 1'b1;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    raddr_a = '0;
    raddr_b = '0;
    clr_req = 1'b0;

    // Reset state
    #1 rst = 1'b0;
    #1;
    push_exp("rst_busy", SelBusy, '0);
    push_exp("rst_done", SelDone, '0);
    drain();
    check_all_zero("rst_rd");
    @(negedge clk);
    rst = 1'b1;

    // Write with same-cycle bypass, then registered read
    write_word(4'd5, 24'hABCDEF);
    raddr_a = 4'd5;
    raddr_b = 4'd6;
    push_exp("byp_a5", SelA, 24'hABCDEF);
    push_exp("byp_b6", SelB, 24'h000000);
    #1 drain();
    @(negedge clk);
    we = 1'b0;
    push_exp("hold_a5", SelA, 24'hABCDEF);
    push_exp("hold_b6", SelB, 24'h000000);
    #1 drain();

    // Both ports bypassing the same write
    write_word(4'd7, 24'h5A5A5A);
    raddr_a = 4'd7;
    raddr_b = 4'd7;
    push_exp("dual_byp_a", SelA, 24'h5A5A5A);
    push_exp("dual_byp_b", SelB, 24'h5A5A5A);
    #1 drain();

    // Fill, then sweep
    for (int i = 0; i < DEPTH; i++) begin
      write_word(AW'(i), 24'h100000 + N'(i));
    end
    @(negedge clk);
    we      = 1'b0;
    clr_req = 1'b1;
    raddr_a = 4'd9;
    push_exp("pre_clr_busy", SelBusy, '0);
    push_exp("pre_clr_a9", SelA, 24'h100009);
    #1 drain();

    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      clr_req = (c == 5);
      we      = (c == 6);
      waddr   = 4'd15;
      wdata   = 24'h123456;
      if (c == 6) begin
        // Dropped write: no bypass, entry 15 still holds pre-sweep data.
        raddr_a = 4'd15;
        raddr_b = 4'd15;
        push_exp("drop_byp_a15", SelA, 24'h10000F);
        push_exp("drop_byp_b15", SelB, 24'h10000F);
      end
      if (c == 8) begin
        raddr_a = 4'd3;
        raddr_b = 4'd12;
        push_exp("mid_a3", SelA, 24'h000000);
        push_exp("mid_b12", SelB, 24'h10000C);
      end
      push_exp($sformatf("sweep_busy_c%0d", c), SelBusy, (c <= 16) ? N'(1) : N'(0));
      push_exp($sformatf("sweep_done_c%0d", c), SelDone, (c == 17) ? N'(1) : N'(0));
      #1 drain();
    end
    we = 1'b0;
    check_all_zero("post_clr");

    // Asynchronous reset in the middle of a sweep
    write_word(4'd9, 24'h999999);
    write_word(4'd2, 24'h222222);
    @(negedge clk);
    we      = 1'b0;
    clr_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      clr_req = 1'b0;
    end
    raddr_a = 4'd9;
    push_exp("pre_rst_busy", SelBusy, N'(1));
    push_exp("pre_rst_a9", SelA, 24'h999999);
    #1 drain();
    #1 rst = 1'b0;
    #1;
    push_exp("arst_busy", SelBusy, '0);
    push_exp("arst_done", SelDone, '0);
    push_exp("arst_a9", SelA, '0);
    drain();
    check_all_zero("arst_rd");
    @(negedge clk);
    rst = 1'b1;
    write_word(4'd2, 24'h55AA55);
    raddr_a = 4'd2;
    push_exp("post_rst_byp_a2", SelA, 24'h55AA55);
    #1 drain();
    @(negedge clk);
    we = 1'b0;
    push_exp("post_rst_a2", SelA, 24'h55AA55);
    push_exp("post_rst_busy", SelBusy, '0);
    #1 drain();

    // Entry 0 behaviour
    write_word(4'd0, 24'hFFFFFF);
    raddr_a = 4'd0;
    raddr_b = 4'd0;
`ifdef REG_BANK_ZERO_REG_EN
    push_exp("zero_byp_a0", SelA, 24'h000000);
    push_exp("zero_byp_b0", SelB, 24'h000000);
`else
    push_exp("zero_byp_a0", SelA, 24'hFFFFFF);
    push_exp("zero_byp_b0", SelB, 24'hFFFFFF);
`endif
    #1 drain();
    write_word(4'd1, 24'h0F0F0F);
    raddr_b = 4'd1;
`ifdef REG_BANK_ZERO_REG_EN
    push_exp("zero_hold_a0", SelA, 24'h000000);
`else
    push_exp("zero_hold_a0", SelA, 24'hFFFFFF);
`endif
    push_exp("a1_byp_b1", SelB, 24'h0F0F0F);
    #1 drain();
    @(negedge clk);
    we = 1'b0;
    push_exp("a1_hold_b1", SelB, 24'h0F0F0F);
    #1 drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
